board_store: RTL

Playfield storage for the 10x20 falling-block game board, sitting directly downstream of the pixel-to-cell address generator. It holds one colour code per cell and returns a registered pixel colour for the cell addressed by the VGA path (address 200 means "outside board"). It also gives the game logic a cell write port, a collision query port, and a multi-cycle line-clear engine that removes full rows and shifts the rows above them down.

---
 rtl/board_store.sv | 120 ++++++++++++
 1 files changed

// File: rtl/board_store.sv
// 10x20 playfield cell store: 1-clk registered pixel read, combinational collision query, multi-cycle line clear.
// Backpressure: writes and clr_start are dropped while busy; a scan takes ROWS + 2*rows_removed cycles.
module board_store #(
    parameter int            COLS      = 10,
    parameter int            ROWS      = 20,
    parameter int            CW        = 3,
    parameter logic [CW-1:0] OUT_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    grid_addr,
    output logic [CW-1:0] pix_color,
    output logic          pix_in_board,
    input  logic          wr_en,
    input  logic [7:0]    wr_addr,
    input  logic [CW-1:0] wr_color,
    input  logic [7:0]    chk_addr,
    output logic          chk_occ,
    input  logic          clr_start,
    output logic          busy,
    output logic          clr_done,
    output logic [4:0]    lines_cleared
);

    localparam int NCELL = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t                   state_q;
    logic [NCELL-1:0][CW-1:0] cells_q;
    logic [4:0]               r_q;
    logic [4:0]               cnt_q;
    logic [4:0]               lines_q;
    logic                     busy_q;
    logic                     done_q;
    logic [CW-1:0]            pix_q;
    logic                     pix_in_q;

    logic                     grid_in;
    logic [CW-1:0]            pix_d;
    logic [7:0]               row_base;
    logic                     row_full;
    logic [7:0]               chk_idx;

    always_comb begin
        grid_in  = (grid_addr < 9'(NCELL));
        pix_d    = grid_in ? cells_q[grid_addr[7:0]] : OUT_COLOR;
        row_base = 8'(r_q) * 8'(COLS);
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (cells_q[row_base + 8'(c)] == '0) row_full = 1'b0;
        end
        chk_idx = (chk_addr < 8'(NCELL)) ? chk_addr : 8'd0;
        chk_occ = (chk_addr >= 8'(NCELL)) || (cells_q[chk_idx] != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cells_q  <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            lines_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pix_q    <= OUT_COLOR;
            pix_in_q <= 1'b0;
        end else begin
            pix_q    <= pix_d;
            pix_in_q <= grid_in;
            done_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Write and start may share an edge; the first SCAN sees the written cell.
                    if (wr_en && (wr_addr < 8'(NCELL))) cells_q[wr_addr] <= wr_color;
                    if (clr_start) begin
                        r_q     <= 5'(ROWS - 1);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        state_q <= SHIFT;
                    end else if (r_q != '0) begin
                        r_q <= r_q - 5'd1;
                    end else begin
                        lines_q <= cnt_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                SHIFT: begin
                    // r_q stays put so the row dropped into it is checked again.
                    for (int i = ROWS - 1; i >= 1; i--) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (5'(i) <= r_q) cells_q[i*COLS + c] <= cells_q[(i-1)*COLS + c];
                        end
                    end
                    for (int c = 0; c < COLS; c++) cells_q[c] <= '0;
                    cnt_q   <= cnt_q + 5'd1;
                    state_q <= SCAN;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pix_color     = pix_q;
    assign pix_in_board  = pix_in_q;
    assign busy          = busy_q;
    assign clr_done      = done_q;
    assign lines_cleared = lines_q;

endmodule
